// File: rtl/mc_cpu_controller.sv
// Multi-cycle control unit for the 16-bit accumulator/window CPU (IF/ID/EX/MEM/WB).
// Define MC_CPU_CTRL_PERF_EN to build the retire/stall performance counters.
module mc_cpu_controller #(
  parameter int FUNC_W = 8,
  parameter int CNT_W  = 32
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic [3:0]        Opcode,
  input  logic [FUNC_W-1:0] Func,
  input  logic              Zero,
  input  logic              MemReady,
  output logic              PCWrite,
  output logic              IRWrite,
  output logic              IorD,
  output logic              MemRead,
  output logic              MemWrite,
  output logic              RegWrite,
  output logic              ALUSrcA,
  output logic              ALUSrcB,
  output logic [2:0]        ALUOp,
  output logic [1:0]        PCSrc,
  output logic [1:0]        WriteControl,
  output logic [1:0]        WndSelect,
  output logic [2:0]        State,
  output logic              IllegalOp,
  output logic [CNT_W-1:0]  RetireCnt,
  output logic [CNT_W-1:0]  StallCnt
);

  typedef enum logic [2:0] {
    S_IF  = 3'b000,
    S_ID  = 3'b001,
    S_EX  = 3'b010,
    S_MEM = 3'b011,
    S_WB  = 3'b100
  } state_t;

  typedef enum logic [3:0] {
    C_LOAD, C_STORE, C_JUMP, C_BRZ, C_NOP,
    C_ALU, C_MOVETO, C_MOVEFROM, C_ILLEGAL
  } cls_t;

  localparam logic [2:0] ALU_ADD   = 3'b000;
  localparam logic [2:0] ALU_SUB   = 3'b001;
  localparam logic [2:0] ALU_AND   = 3'b010;
  localparam logic [2:0] ALU_OR    = 3'b011;
  localparam logic [2:0] ALU_NOT   = 3'b100;
  localparam logic [2:0] ALU_PASSB = 3'b101;

  state_t state_q, state_d;
  cls_t   cls_q, cls_d, dec_cls;
  logic [2:0] aluop_q, aluop_d, dec_aluop;
  logic       srcb_q, srcb_d, dec_srcb;

  // Zero-padded so the one-hot byte and the must-be-zero upper bits work for any FUNC_W.
  logic [FUNC_W+7:0] func_ext;
  logic              func_hi_zero;

  assign func_ext     = {8'b0, Func};
  assign func_hi_zero = ((func_ext >> 8) == '0);

  always_comb begin
    dec_cls   = C_ILLEGAL;
    dec_aluop = ALU_ADD;
    dec_srcb  = 1'b0;
    case (Opcode)
      4'b0000: dec_cls = C_LOAD;
      4'b0001: dec_cls = C_STORE;
      4'b0010: dec_cls = C_JUMP;
      4'b0100: dec_cls = C_BRZ;
      4'b1000: begin
        if (func_hi_zero) begin
          case (func_ext[7:0])
            8'h01: dec_cls = C_MOVETO;
            8'h02: begin dec_cls = C_MOVEFROM; dec_aluop = ALU_PASSB; end
            8'h04: begin dec_cls = C_ALU;      dec_aluop = ALU_ADD;   end
            8'h08: begin dec_cls = C_ALU;      dec_aluop = ALU_SUB;   end
            8'h10: begin dec_cls = C_ALU;      dec_aluop = ALU_AND;   end
            8'h20: begin dec_cls = C_ALU;      dec_aluop = ALU_OR;    end
            8'h40: begin dec_cls = C_ALU;      dec_aluop = ALU_NOT;   end
            8'h80: dec_cls = C_NOP;
            default: dec_cls = C_ILLEGAL;
          endcase
        end
      end
      4'b1100: begin dec_cls = C_ALU; dec_aluop = ALU_ADD; dec_srcb = 1'b1; end
      4'b1101: begin dec_cls = C_ALU; dec_aluop = ALU_SUB; dec_srcb = 1'b1; end
      4'b1110: begin dec_cls = C_ALU; dec_aluop = ALU_AND; dec_srcb = 1'b1; end
      4'b1111: begin dec_cls = C_ALU; dec_aluop = ALU_OR;  dec_srcb = 1'b1; end
      default: dec_cls = C_ILLEGAL;
    endcase
  end

  // Decode is captured on leaving ID so EX/MEM/WB outputs are pure Moore terms.
  always_comb begin
    cls_d   = cls_q;
    aluop_d = aluop_q;
    srcb_d  = srcb_q;
    if (state_q == S_ID) begin
      cls_d   = dec_cls;
      aluop_d = dec_aluop;
      srcb_d  = dec_srcb;
    end
  end

  always_ff @(posedge Clk) begin
    cls_q   <= cls_d;
    aluop_q <= aluop_d;
    srcb_q  <= srcb_d;
  end

  logic       pc_write_c, ir_write_c, iord_c, mem_read_c, mem_write_c, reg_write_c;
  logic       alu_src_a_c, alu_src_b_c, illegal_c;
  logic [2:0] alu_op_c;
  logic [1:0] pc_src_c, write_ctrl_c, wnd_sel_c;
  logic       retire_inc, stall_inc;

  always_comb begin
    state_d      = state_q;
    pc_write_c   = 1'b0;
    ir_write_c   = 1'b0;
    iord_c       = 1'b0;
    mem_read_c   = 1'b0;
    mem_write_c  = 1'b0;
    reg_write_c  = 1'b0;
    alu_src_a_c  = 1'b0;
    alu_src_b_c  = 1'b0;
    illegal_c    = 1'b0;
    alu_op_c     = ALU_ADD;
    pc_src_c     = 2'b00;
    write_ctrl_c = 2'b00;
    wnd_sel_c    = 2'b00;
    retire_inc   = 1'b0;
    stall_inc    = 1'b0;
    case (state_q)
      S_IF: begin
        mem_read_c = 1'b1;
        if (MemReady) begin
          ir_write_c = 1'b1;
          pc_write_c = 1'b1;
          state_d    = S_ID;
        end else begin
          stall_inc = 1'b1;
        end
      end
      S_ID: begin
        case (dec_cls)
          C_JUMP: begin
            pc_write_c = 1'b1;
            pc_src_c   = 2'b10;
            retire_inc = 1'b1;
            state_d    = S_IF;
          end
          C_BRZ: begin
            pc_write_c = Zero;
            pc_src_c   = 2'b01;
            retire_inc = 1'b1;
            state_d    = S_IF;
          end
          C_NOP: begin
            retire_inc = 1'b1;
            state_d    = S_IF;
          end
          C_ILLEGAL: begin
            illegal_c = 1'b1;
            state_d   = S_IF;
          end
          C_LOAD, C_STORE: state_d = S_MEM;
          default:         state_d = S_EX;
        endcase
      end
      S_EX: begin
        alu_src_a_c = 1'b1;
        alu_src_b_c = srcb_q;
        alu_op_c    = aluop_q;
        state_d     = S_WB;
      end
      S_MEM: begin
        iord_c = 1'b1;
        if (cls_q == C_STORE) mem_write_c = 1'b1;
        else                  mem_read_c  = 1'b1;
        if (MemReady) begin
          if (cls_q == C_STORE) begin
            retire_inc = 1'b1;
            state_d    = S_IF;
          end else begin
            state_d = S_WB;
          end
        end else begin
          stall_inc = 1'b1;
        end
      end
      S_WB: begin
        reg_write_c = 1'b1;
        retire_inc  = 1'b1;
        state_d     = S_IF;
        case (cls_q)
          C_LOAD:     write_ctrl_c = 2'b01;
          C_MOVETO:   begin write_ctrl_c = 2'b10; wnd_sel_c = 2'b01; end
          C_MOVEFROM: alu_op_c = ALU_PASSB;
          default:    write_ctrl_c = 2'b00;
        endcase
      end
      default: state_d = S_IF;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Rst) state_q <= S_IF;
    else     state_q <= state_d;
  end

  // Reset forces every output low in the same cycle, whatever state was left behind.
  assign PCWrite      = ~Rst & pc_write_c;
  assign IRWrite      = ~Rst & ir_write_c;
  assign IorD         = ~Rst & iord_c;
  assign MemRead      = ~Rst & mem_read_c;
  assign MemWrite     = ~Rst & mem_write_c;
  assign RegWrite     = ~Rst & reg_write_c;
  assign ALUSrcA      = ~Rst & alu_src_a_c;
  assign ALUSrcB      = ~Rst & alu_src_b_c;
  assign IllegalOp    = ~Rst & illegal_c;
  assign ALUOp        = Rst ? 3'b000 : alu_op_c;
  assign PCSrc        = Rst ? 2'b00  : pc_src_c;
  assign WriteControl = Rst ? 2'b00  : write_ctrl_c;
  assign WndSelect    = Rst ? 2'b00  : wnd_sel_c;
  assign State        = Rst ? 3'b000 : state_q;

`ifdef MC_CPU_CTRL_PERF_EN
  logic [CNT_W-1:0] retire_cnt_q, retire_cnt_d, stall_cnt_q, stall_cnt_d;

  always_comb begin
    retire_cnt_d = retire_cnt_q + {{(CNT_W-1){1'b0}}, retire_inc};
    stall_cnt_d  = stall_cnt_q  + {{(CNT_W-1){1'b0}}, stall_inc};
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      retire_cnt_q <= '0;
      stall_cnt_q  <= '0;
    end else begin
      retire_cnt_q <= retire_cnt_d;
      stall_cnt_q  <= stall_cnt_d;
    end
  end

  assign RetireCnt = Rst ? '0 : retire_cnt_q;
  assign StallCnt  = Rst ? '0 : stall_cnt_q;
`else
  logic unused_perf;
  assign unused_perf = retire_inc ^ stall_inc;
  assign RetireCnt   = '0;
  assign StallCnt    = '0;
`endif

endmodule

// File: tb/tb_mc_cpu_controller.sv
// Self-checking bench for mc_cpu_controller: directed and random instruction streams
// checked cycle by cycle against an instruction-level reference model.
module tb_mc_cpu_controller;
  localparam int FUNC_W = 8;
  localparam int CNT_W  = 32;
`ifdef MC_CPU_CTRL_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic              Clk = 1'b0;
  logic              Rst = 1'b1;
  logic [3:0]        Opcode = 4'h0;
  logic [FUNC_W-1:0] Func = '0;
  logic              Zero = 1'b0;
  logic              MemReady = 1'b1;
  logic              PCWrite, IRWrite, IorD, MemRead, MemWrite, RegWrite, ALUSrcA, ALUSrcB;
  logic [2:0]        ALUOp;
  logic [1:0]        PCSrc, WriteControl, WndSelect;
  logic [2:0]        State;
  logic              IllegalOp;
  logic [CNT_W-1:0]  RetireCnt, StallCnt;

  always #5 Clk = ~Clk;

  mc_cpu_controller #(.FUNC_W(FUNC_W), .CNT_W(CNT_W)) dut (
    .Clk(Clk), .Rst(Rst), .Opcode(Opcode), .Func(Func), .Zero(Zero), .MemReady(MemReady),
    .PCWrite(PCWrite), .IRWrite(IRWrite), .IorD(IorD), .MemRead(MemRead), .MemWrite(MemWrite),
    .RegWrite(RegWrite), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .PCSrc(PCSrc),
    .WriteControl(WriteControl), .WndSelect(WndSelect), .State(State), .IllegalOp(IllegalOp),
    .RetireCnt(RetireCnt), .StallCnt(StallCnt)
  );

  typedef struct packed {
    logic [2:0] st;
    logic       pcw, irw, iord, mrd, mwr, rgw, srca, srcb;
    logic [2:0] aluop;
    logic [1:0] pcsrc, wc, wnd;
    logic       ill;
  } obs_t;

  obs_t obs;
  assign obs = {State, PCWrite, IRWrite, IorD, MemRead, MemWrite, RegWrite, ALUSrcA, ALUSrcB,
                ALUOp, PCSrc, WriteControl, WndSelect, IllegalOp};

  localparam int K_LOAD = 0, K_STORE = 1, K_JUMP = 2, K_BRZ = 3, K_NOP = 4;
  localparam int K_RALU = 5, K_IMM = 6, K_MOVETO = 7, K_MOVEFROM = 8, K_ILL = 9;

  int checks = 0;
  int errors = 0;
  logic [CNT_W-1:0] ret_m = '0;
  logic [CNT_W-1:0] stl_m = '0;

  function automatic int kind_of(input logic [3:0] op, input logic [7:0] fn);
    case (op)
      4'h0: return K_LOAD;
      4'h1: return K_STORE;
      4'h2: return K_JUMP;
      4'h4: return K_BRZ;
      4'h8: begin
        if ($countones(fn) != 1) return K_ILL;
        if (fn[0]) return K_MOVETO;
        if (fn[1]) return K_MOVEFROM;
        if (fn[7]) return K_NOP;
        return K_RALU;
      end
      4'hC, 4'hD, 4'hE, 4'hF: return K_IMM;
      default: return K_ILL;
    endcase
  endfunction

  function automatic logic [2:0] alu_of(input logic [3:0] op, input logic [7:0] fn);
    case (op)
      4'hC: return 3'd0;
      4'hD: return 3'd1;
      4'hE: return 3'd2;
      4'hF: return 3'd3;
      default: begin
        for (int b = 2; b <= 6; b++)
          if (fn[b]) return 3'(b - 2);
        return 3'd0;
      end
    endcase
  endfunction

  function automatic obs_t at(input logic [2:0] s);
    obs_t e;
    e = '0;
    e.st = s;
    return e;
  endfunction

  task automatic cycle(input obs_t e, input obs_t m, input logic mr, input logic z,
                       input logic [3:0] op, input logic [7:0] fn,
                       input bit ret, input bit stl, input string tag);
    logic [2*CNT_W-1:0] cnt_e;
    MemReady = mr;
    Zero     = z;
    Opcode   = op;
    Func     = fn;
    #2;
    checks++;
    assert ((obs & m) === (e & m)) else begin
      errors++;
      $error("FAIL %s outputs: observed %h expected %h", tag, obs & m, e & m);
    end
    cnt_e = PERF ? {ret_m, stl_m} : '0;
    checks++;
    assert ({RetireCnt, StallCnt} === cnt_e) else begin
      errors++;
      $error("FAIL %s counters: observed ret=%0d stall=%0d expected ret=%0d stall=%0d",
             tag, RetireCnt, StallCnt, cnt_e[2*CNT_W-1:CNT_W], cnt_e[CNT_W-1:0]);
    end
    if (ret) ret_m = ret_m + 1'b1;
    if (stl) stl_m = stl_m + 1'b1;
    @(posedge Clk);
    #1;
  endtask

  task automatic reset_cycles(input int n, input string tag);
    Rst = 1'b1;
    for (int i = 0; i < n; i++) begin
      MemReady = 1'b1;
      Zero     = 1'($urandom);
      #2;
      checks++;
      assert (obs === '0) else begin
        errors++;
        $error("FAIL %s reset outputs: observed %h expected 0", tag, obs);
      end
      checks++;
      assert ({RetireCnt, StallCnt} === '0) else begin
        errors++;
        $error("FAIL %s reset counters: observed ret=%0d stall=%0d expected 0", tag, RetireCnt, StallCnt);
      end
      @(posedge Clk);
      #1;
    end
    Rst   = 1'b0;
    ret_m = '0;
    stl_m = '0;
  endtask

  task automatic fetch(input int wif, input string tag);
    obs_t e, full;
    full = '1;
    for (int i = 0; i < wif; i++) begin
      e = at(3'b000); e.mrd = 1'b1;
      cycle(e, full, 1'b0, 1'($urandom), 4'($urandom), 8'($urandom), 1'b0, 1'b1, {tag, "/IFw"});
    end
    e = at(3'b000); e.mrd = 1'b1; e.irw = 1'b1; e.pcw = 1'b1;
    cycle(e, full, 1'b1, 1'($urandom), 4'($urandom), 8'($urandom), 1'b0, 1'b0, {tag, "/IF"});
  endtask

  task automatic run_instr(input logic [3:0] op, input logic [7:0] fn, input logic z,
                           input int wif, input int wmem, input string tag);
    obs_t e, full, m;
    int   k;
    full = '1;
    k = kind_of(op, fn);
    fetch(wif, tag);
    e = at(3'b001);
    case (k)
      K_JUMP: begin e.pcw = 1'b1; e.pcsrc = 2'b10; end
      K_BRZ:  begin e.pcw = z;    e.pcsrc = 2'b01; end
      K_ILL:  e.ill = 1'b1;
      default: ;
    endcase
    cycle(e, full, 1'($urandom), z, op, fn,
          (k == K_JUMP || k == K_BRZ || k == K_NOP), 1'b0, {tag, "/ID"});
    if (k == K_LOAD || k == K_STORE) begin
      for (int i = 0; i <= wmem; i++) begin
        e = at(3'b011); e.iord = 1'b1;
        if (k == K_STORE) e.mwr = 1'b1; else e.mrd = 1'b1;
        cycle(e, full, (i == wmem), 1'($urandom), op, fn,
              (i == wmem && k == K_STORE), (i != wmem), {tag, "/MEM"});
      end
      if (k == K_LOAD) begin
        e = at(3'b100); e.rgw = 1'b1; e.wc = 2'b01;
        cycle(e, full, 1'($urandom), 1'($urandom), op, fn, 1'b1, 1'b0, {tag, "/WB"});
      end
    end else if (k == K_RALU || k == K_IMM || k == K_MOVETO || k == K_MOVEFROM) begin
      e = at(3'b010); e.srca = 1'b1; e.srcb = (k == K_IMM);
      m = full;
      if (k == K_MOVETO || k == K_MOVEFROM) m.aluop = 3'b000;
      else e.aluop = alu_of(op, fn);
      cycle(e, m, 1'($urandom), 1'($urandom), op, fn, 1'b0, 1'b0, {tag, "/EX"});
      e = at(3'b100); e.rgw = 1'b1;
      if (k == K_MOVETO) begin e.wc = 2'b10; e.wnd = 2'b01; end
      if (k == K_MOVEFROM) e.aluop = 3'b101;
      cycle(e, full, 1'($urandom), 1'($urandom), op, fn, 1'b1, 1'b0, {tag, "/WB"});
    end
  endtask

  initial begin
    logic [3:0] legal_ops [9];
    logic [3:0] op;
    logic [7:0] fn;
    obs_t e, full;
    full = '1;
    legal_ops = '{4'h0, 4'h1, 4'h2, 4'h4, 4'h8, 4'hC, 4'hD, 4'hE, 4'hF};

    #1;
    reset_cycles(2, "reset");

    run_instr(4'hC, 8'h05, 1'b0, 0, 0, "addi");
    run_instr(4'h0, 8'h10, 1'b1, 0, 3, "load_wait3");
    run_instr(4'h4, 8'h00, 1'b0, 0, 0, "brz_z0");
    run_instr(4'h4, 8'h00, 1'b1, 0, 0, "brz_z1");
    run_instr(4'h8, 8'h0C, 1'b0, 0, 0, "rtype_twohot");
    run_instr(4'h3, 8'h00, 1'b0, 0, 0, "op0011");
    run_instr(4'h8, 8'h00, 1'b0, 0, 0, "rtype_nobits");
    run_instr(4'h1, 8'h33, 1'b0, 2, 1, "store");
    run_instr(4'h2, 8'hA5, 1'b0, 1, 0, "jump");
    run_instr(4'h8, 8'h80, 1'b1, 0, 0, "nop");
    run_instr(4'h8, 8'h01, 1'b0, 0, 0, "moveto");
    run_instr(4'h8, 8'h02, 1'b0, 0, 0, "movefrom");
    for (int b = 2; b <= 6; b++)
      run_instr(4'h8, 8'(1 << b), 1'b0, b - 2, 0, "rtype_alu");
    run_instr(4'hD, 8'hFF, 1'b0, 0, 0, "subi");
    run_instr(4'hE, 8'h0F, 1'b0, 0, 0, "andi");
    run_instr(4'hF, 8'hF0, 1'b0, 0, 0, "ori");

    for (int n = 0; n < 250; n++) begin
      op = 4'($urandom);
      if ($urandom_range(3, 0) != 0) op = legal_ops[$urandom_range(8, 0)];
      fn = 8'($urandom);
      if (op == 4'h8 && $urandom_range(3, 0) != 0) fn = 8'(1 << $urandom_range(7, 0));
      run_instr(op, fn, 1'($urandom), $urandom_range(3, 0), $urandom_range(3, 0), "random");
    end

    // Abandon a STORE while it waits in MEM; memory is ready during the reset cycle.
    fetch(0, "store_abort");
    cycle(at(3'b001), full, 1'b0, 1'b0, 4'h1, 8'h00, 1'b0, 1'b0, "store_abort/ID");
    e = at(3'b011); e.iord = 1'b1; e.mwr = 1'b1;
    cycle(e, full, 1'b0, 1'b0, 4'h1, 8'h00, 1'b0, 1'b1, "store_abort/MEM");
    reset_cycles(1, "store_abort/rst");
    run_instr(4'hC, 8'h01, 1'b0, 0, 0, "after_abort");
    run_instr(4'h2, 8'h00, 1'b0, 0, 0, "after_abort_jump");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mc_cpu_controller.md
# mc_cpu_controller

Multi-cycle control unit for the 16-bit accumulator/window CPU. It is the successor to the single-cycle controller. It sequences each instruction through fetch, decode, execute, memory and write-back states. Memory accesses wait on a ready handshake. It sits between the instruction register and the multi-cycle datapath, and exposes optional performance counters.

## Interface
- FUNC_W, 8, width of the function field; bits above [7] must be zero or the instruction is illegal
- CNT_W, 32, width of the retire and stall counters (minimum 8)
- Clk  in  1  rising-edge clock
- Rst  in  1  synchronous, active-high reset
- Opcode  in  4  instruction bits [15:12], valid from the ID state onward
- Func  in  FUNC_W  instruction bits [FUNC_W-1:0]
- Zero  in  1  ALU zero flag for the accumulator (R0)
- MemReady  in  1  memory completes the current MemRead/MemWrite this cycle
- PCWrite, IRWrite, IorD, MemRead, MemWrite, RegWrite, ALUSrcA  out  1 each  datapath strobes and selects
- ALUSrcB  out  1  0 = register, 1 = zero-extended Instr[11:0]
- ALUOp  out  3  000 add, 001 sub, 010 and, 011 or, 100 not A, 101 pass B
- PCSrc  out  2  00 PC+1, 01 PC + sign-extended Instr[11:0], 10 Instr[11:0]
- WriteControl  out  2  00 ALU result, 01 memory data, 10 R0 value
- WndSelect  out  2  destination: 00 R0, 01 Ri (Instr[11:10])
- State  out  3  current state encoding
- IllegalOp  out  1  one-cycle pulse on an undecodable instruction
- RetireCnt, StallCnt  out  CNT_W each  performance counters (see Configuration)

## Operation
- States: IF=000, ID=001, EX=010, MEM=011, WB=100. Encodings 101–111 recover to IF on the next edge.
- Opcodes: 0000 LOAD, 0001 STORE, 0010 JUMP, 0100 BRZ, 1000 R-type, 1100 ADDI, 1101 SUBI, 1110 ANDI, 1111 ORI. All others are illegal.
- R-type Func is one-hot:
  - bit 0 MOVETO: Ri ← R0
  - bit 1 MOVEFROM: R0 ← Ri
  - bit 2 ADD, bit 3 SUB, bit 4 AND, bit 5 OR, bit 6 NOT: R0 ← R0 op Ri
  - bit 7 NOP
  - zero bits set, or more than one bit set, is illegal.
- IF: MemRead=1, IorD=0.
  - While MemReady=0: stay in IF; StallCnt increments.
  - On MemReady=1: IRWrite=1, PCWrite=1 with PCSrc=00, then go to ID.
- ID:
  - JUMP: PCWrite=1, PCSrc=10, go to IF.
  - BRZ: PCSrc=01, PCWrite=Zero, go to IF.
  - NOP: go to IF.
  - Illegal: IllegalOp=1, go to IF, no retire.
  - LOAD/STORE: go to MEM.
  - R-type (except NOP) and immediates: go to EX.
- EX: ALUOp and ALUSrcB are driven from the opcode/Func decode; ALUSrcA=1 (R0); go to WB.
- MEM: IorD=1.
  - LOAD: MemRead=1; stay until MemReady, then go to WB.
  - STORE: MemWrite=1; stay until MemReady, then go to IF.
  - Every waiting cycle increments StallCnt.
- WB: RegWrite=1, then go to IF.
  - LOAD: WriteControl=01, WndSelect=00.
  - MOVETO: WriteControl=10, WndSelect=01.
  - MOVEFROM: ALUOp=101, WriteControl=00, WndSelect=00.
  - Other R-type and immediates: WriteControl=00, WndSelect=00.
- Retire: RetireCnt increments on the exit transition of every legal instruction. That is ID→IF for JUMP/BRZ/NOP, MEM→IF for STORE, and WB→IF otherwise.
- Counters wrap modulo 2^CNT_W. Retire and stall increments never coincide.

## Timing
- Outputs are Moore decodes of State and latched decode, except two Mealy terms:
  - IRWrite/PCWrite in IF, gated by MemReady
  - PCWrite in ID for BRZ, gated by Zero.
- Rst high:
  - all control outputs, IllegalOp and State are 0, and counters are 0, combinationally during the reset cycle
  - at the next edge: State=IF.
  - Reset mid-instruction abandons it: no retire, no register or memory write after the edge.
- Cycles with zero-wait memory: JUMP/BRZ/NOP 2, STORE 3, R-type/immediate 4, LOAD 4.
- Each memory wait cycle adds exactly 1 cycle.
- MemReady outside IF/MEM is ignored.
- MemRead and MemWrite are held stable until the MemReady cycle inclusive and never assert together.

## Configuration
- MC_CPU_CTRL_PERF_EN defined: RetireCnt and StallCnt are live registers as described.
- Not defined: both outputs are tied to 0 and no counter flops are synthesised. All other behaviour is identical.

## Test plan
- Reset: Rst=1 for 2 cycles with MemReady=1 → all outputs 0. First cycle after release: State=000, MemRead=1, IorD=0.
- ADDI 0x005, MemReady=1 → states IF, ID, EX, WB. EX: ALUOp=000, ALUSrcB=1. WB: RegWrite=1. RetireCnt=1 after 4 cycles.
- LOAD with MemReady low 3 cycles in MEM → MEM held 4 cycles with MemRead=1, IorD=1. Then WB with WriteControl=01. StallCnt=3, RetireCnt=1.
- BRZ with Zero=0, then BRZ with Zero=1 → PCWrite stays 0 in the first ID. PCWrite=1 with PCSrc=01 in the second ID. Each instruction takes 2 cycles.
- R-type with Func=0x0C, then opcode 0011 → IllegalOp pulses in ID for each. Next state IF, RetireCnt unchanged, no RegWrite.
- Rst asserted during MEM of a STORE → MemWrite=0 in the reset cycle, State=IF after the edge, RetireCnt=0.
